// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared funct codes, controller state encoding and a helper that
//            folds unknown funct codes onto ADD.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MULTU = 6'b011001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Unknown codes are executed as ADD, so they are normalised at latch time.
   function automatic logic [5:0] funct_norm(input logic [5:0] f);
      case (f)
         F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_MULTU: return f;
         default:                                  return F_ADD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_ctrl_if
// Purpose  : Request/result handshake plus the shared ALU bus of the
//            sequencer. The master side issues requests and hosts the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mul_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [5:0]       req_funct;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [5:0]       alu_signal;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_sum;
   logic             alu_cout;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;

   modport master (
      output req_valid, req_funct, req_a, req_b, alu_sum, alu_cout,
      input  req_ready, alu_signal, alu_a, alu_b, busy, done, result_lo, result_hi
   );

   modport slave (
      input  req_valid, req_funct, req_a, req_b, alu_sum, alu_cout,
      output req_ready, alu_signal, alu_a, alu_b, busy, done, result_lo, result_hi
   );
endinterface
`default_nettype wire

// File: rtl/alu_mul_shreg.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_shreg
// Purpose  : {hi,lo} product register for the shift-add multiplier. Loads the
//            multiplier into lo, then each step either adds-and-shifts (lo[0]=1)
//            or just shifts. The next value is exported so the final product
//            can be captured on the last step.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_shreg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_nxt_hi,
   output logic [WIDTH-1:0] o_nxt_lo
);
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_nxt_hi;
   logic [WIDTH-1:0] w_nxt_lo;

   // Next product value: {cout,sum,lo>>1} on a set multiplier bit, else {0,hi,lo>>1}.
   always_comb begin
      w_nxt_hi = {1'b0, r_hi[WIDTH-1:1]};
      w_nxt_lo = {r_hi[0], r_lo[WIDTH-1:1]};
      if (r_lo[0]) begin
         w_nxt_hi = {i_cout, i_sum[WIDTH-1:1]};
         w_nxt_lo = {i_sum[0], r_lo[WIDTH-1:1]};
      end
   end

   // Product register: load at MULTU acceptance, advance once per iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_load) begin
         r_hi <= '0;
         r_lo <= i_b;
      end else if (i_step) begin
         r_hi <= w_nxt_hi;
         r_lo <= w_nxt_lo;
      end
   end

   assign o_hi     = r_hi;
   assign o_nxt_hi = w_nxt_hi;
   assign o_nxt_lo = w_nxt_lo;

endmodule
`default_nettype wire

// File: rtl/alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_ctrl
// Purpose  : Sequencer owning an external shared ALU. Single-cycle ops are
//            issued for one EXEC cycle; MULTU runs WIDTH shift-add iterations
//            through the ALU adder. Results are held until the next completion.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_mul_ctrl_if.slave  bus
);
   state_t           r_state;
   state_t           w_state_nxt;
   logic [5:0]       r_funct;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_res_lo;
   logic [WIDTH-1:0] r_res_hi;

   logic             w_xfer;
   logic             w_is_mul;
   logic             w_last;
   logic [5:0]       w_alu_sig;
   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_nxt_hi;
   logic [WIDTH-1:0] w_nxt_lo;
   logic             w_slt_ovf;
   logic             w_slt_bit;

   assign w_xfer    = bus.req_valid && bus.req_ready;
   assign w_is_mul  = (bus.req_funct == F_MULTU);
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   // Signed less-than from the SUB result, corrected for two's-complement overflow.
   assign w_slt_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (bus.alu_sum[WIDTH-1] != r_a[WIDTH-1]);
   assign w_slt_bit = bus.alu_sum[WIDTH-1] ^ w_slt_ovf;

   alu_mul_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_xfer && w_is_mul),
      .i_step   (r_state == S_MUL),
      .i_b      (bus.req_b),
      .i_sum    (bus.alu_sum),
      .i_cout   (bus.alu_cout),
      .o_hi     (w_hi),
      .o_nxt_hi (w_nxt_hi),
      .o_nxt_lo (w_nxt_lo)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and ALU bus drive; the ALU idles on ADD 0+0.
   always_comb begin
      w_state_nxt = r_state;
      w_alu_sig   = F_ADD;
      w_alu_a     = '0;
      w_alu_b     = '0;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) w_state_nxt = w_is_mul ? S_MUL : S_EXEC;
         end
         S_EXEC: begin
            w_alu_sig   = (r_funct == F_SLT) ? F_SUB : r_funct;
            w_alu_a     = r_a;
            w_alu_b     = r_b;
            w_state_nxt = S_DONE;
         end
         S_MUL: begin
            w_alu_a = w_hi;
            w_alu_b = r_a;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, iteration counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_funct  <= F_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_res_lo <= '0;
         r_res_hi <= '0;
      end else begin
         if (w_xfer) begin
            r_funct <= funct_norm(bus.req_funct);
            r_a     <= bus.req_a;
            r_b     <= bus.req_b;
            r_cnt   <= '0;
         end
         if (r_state == S_EXEC) begin
            r_res_hi <= '0;
            r_res_lo <= (r_funct == F_SLT) ? {{(WIDTH-1){1'b0}}, w_slt_bit} : bus.alu_sum;
         end
         if (r_state == S_MUL) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_res_hi <= w_nxt_hi;
               r_res_lo <= w_nxt_lo;
            end
         end
      end
   end

   // Ready is withheld while reset is asserted.
   assign bus.req_ready  = (r_state == S_IDLE) && rst_n;
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.result_lo  = r_res_lo;
   assign bus.result_hi  = r_res_hi;
   assign bus.alu_signal = w_alu_sig;
   assign bus.alu_a      = w_alu_a;
   assign bus.alu_b      = w_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_ctrl
// Purpose  : Directed self-checking bench for alu_mul_ctrl with a behavioural
//            ALU bound to the shared ALU bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_ctrl;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [WIDTH:0] alu_t;

   always #5 clk = ~clk;

   alu_mul_ctrl_if #(.WIDTH(WIDTH)) bus ();

   alu_mul_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural ALU: AND, OR, ADD, SUB with MSB carry-out.
   always_comb begin
      alu_t        = '0;
      bus.alu_sum  = '0;
      bus.alu_cout = 1'b0;
      case (bus.alu_signal)
         F_AND: bus.alu_sum = bus.alu_a & bus.alu_b;
         F_OR:  bus.alu_sum = bus.alu_a | bus.alu_b;
         F_ADD: begin
            alu_t        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_sum  = alu_t[WIDTH-1:0];
            bus.alu_cout = alu_t[WIDTH];
         end
         F_SUB: begin
            alu_t        = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{WIDTH{1'b0}}, 1'b1};
            bus.alu_sum  = alu_t[WIDTH-1:0];
            bus.alu_cout = alu_t[WIDTH];
         end
         default: bus.alu_sum = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transaction; edges counted including the transfer edge.
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_edges);
      int edges;
      bit seen;
      @(negedge clk);
      chk({tag, " ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_funct = f;
      bus.req_a     = a;
      bus.req_b     = b;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      edges = 1;
      seen  = bus.done;
      while (!seen && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         seen = bus.done;
      end
      chk({tag, " edges"}, 64'(edges), 64'(exp_edges));
      chk({tag, " lo"}, 64'(bus.result_lo), 64'(exp_lo));
      chk({tag, " hi"}, 64'(bus.result_hi), 64'(exp_hi));
      chk({tag, " busy@done"}, 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1;
      chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
      chk({tag, " held"}, 64'(bus.result_lo), 64'(exp_lo));
   endtask

   initial begin : main
      int lowcnt;
      int dones;
      logic [31:0] mlo;
      logic [31:0] mhi;
      bus.req_valid = 1'b0;
      bus.req_funct = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      mlo = '0;
      mhi = '0;

      // Reset state
      #12;
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst done", 64'(bus.done), 64'd0);
      chk("rst lo", 64'(bus.result_lo), 64'd0);
      chk("rst hi", 64'(bus.result_hi), 64'd0);
      chk("rst sig", 64'(bus.alu_signal), 64'(6'b100000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel ready", 64'(bus.req_ready), 64'd1);

      // Single-cycle ops
      run_op("add ovf", F_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2);
      run_op("sub",     F_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 32'h0, 2);
      run_op("and",     F_AND, 32'hF0F0, 32'hFF00, 32'hF000, 32'h0, 2);
      run_op("or",      F_OR,  32'hF0F0, 32'hFF00, 32'hFFF0, 32'h0, 2);
      run_op("slt neg", F_SLT, 32'h8000_0000, 32'h1, 32'h1, 32'h0, 2);
      run_op("slt ovf", F_SLT, 32'h1, 32'h8000_0000, 32'h0, 32'h0, 2);
      run_op("slt eq",  F_SLT, 32'h7, 32'h7, 32'h0, 32'h0, 2);
      run_op("slt lt",  F_SLT, 32'h2, 32'h5, 32'h1, 32'h0, 2);

      // Multiplies
      run_op("mul max",  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, WIDTH + 1);
      run_op("mul zero", F_MULTU, 32'h1234_5678, 32'h0, 32'h0, 32'h0, WIDTH + 1);
      run_op("mul 3x5",  F_MULTU, 32'h3, 32'h5, 32'd15, 32'h0, WIDTH + 1);
      run_op("mul mid",  F_MULTU, 32'h0001_0000, 32'h0003_0001, 32'h0001_0000, 32'h0000_0003, WIDTH + 1);

      // Unknown funct behaves as ADD
      run_op("unk", 6'b000111, 32'h2, 32'h3, 32'h5, 32'h0, 2);

      // Back-to-back: MULTU then ADD with valid held high
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_funct = F_MULTU;
      bus.req_a     = 32'h3;
      bus.req_b     = 32'h5;
      @(posedge clk);
      #1;
      bus.req_funct = F_ADD;
      bus.req_a     = 32'd10;
      bus.req_b     = 32'd20;
      lowcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.req_ready) break;
         lowcnt++;
         if (bus.done) begin
            mlo = bus.result_lo;
            mhi = bus.result_hi;
         end
      end
      chk("b2b ready low", 64'(lowcnt), 64'(WIDTH + 1));
      chk("b2b mul lo", 64'(mlo), 64'd15);
      chk("b2b mul hi", 64'(mhi), 64'd0);
      @(negedge clk);
      chk("b2b exec ready", 64'(bus.req_ready), 64'd0);
      chk("b2b exec busy", 64'(bus.busy), 64'd1);
      bus.req_funct = F_AND;
      bus.req_a     = 32'hF;
      bus.req_b     = 32'h3;
      @(negedge clk);
      chk("b2b add done", 64'(bus.done), 64'd1);
      chk("b2b add lo", 64'(bus.result_lo), 64'd30);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("b2b idle busy", 64'(bus.busy), 64'd0);
      chk("b2b idle ready", 64'(bus.req_ready), 64'd1);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("b2b third dropped", 64'(dones), 64'd0);
      chk("b2b lo held", 64'(bus.result_lo), 64'd30);

      // Reset in the middle of a MULTU
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_funct = F_MULTU;
      bus.req_a     = 32'h1234;
      bus.req_b     = 32'hFFFF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("mid busy before", 64'(bus.busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid rst busy", 64'(bus.busy), 64'd0);
      chk("mid rst done", 64'(bus.done), 64'd0);
      chk("mid rst lo", 64'(bus.result_lo), 64'd0);
      chk("mid rst hi", 64'(bus.result_hi), 64'd0);
      chk("mid rst alu_a", 64'(bus.alu_a), 64'd0);
      chk("mid rst alu_b", 64'(bus.alu_b), 64'd0);
      chk("mid rst sig", 64'(bus.alu_signal), 64'(6'b100000));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid rel ready", 64'(bus.req_ready), 64'd1);
      dones = 0;
      for (int i = 0; i < WIDTH + 8; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("mid no done", 64'(dones), 64'd0);
      run_op("add after rst", F_ADD, 32'd5, 32'd7, 32'd12, 32'h0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
